// File: rtl/memshare_rqst_sched_if.sv
// Read-request handshake between the memShare scheduler
// and the message-passing buffer read port.
interface memshare_rqst_sched_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;

  modport master (
    output valid,
    output addr,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    output ready
  );
endinterface

// File: rtl/memshare_rqst_sched.sv
// Sequences one SCU.memShare() period of buffer read requests:
// rebase, issue RQST_NUM requests with DRC stall/skip, drain, done.
module memshare_rqst_sched #(
  parameter int ADDR_WIDTH = 6,
  parameter int ADDR_BASE  = 0,
  parameter int RQST_NUM   = 16,
  parameter int DRC_NUM    = 2,
  parameter int DRAIN_CYC  = 2
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [DRC_NUM-1:0]    is_drc_i,
  input  logic [ADDR_WIDTH-1:0] skip_operand_i,
  memshare_rqst_sched_if.master rqst,
  output logic                  scu_begin_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CW = (RQST_NUM > 1) ? $clog2(RQST_NUM) : 1;
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(ADDR_BASE);
  localparam logic [CW-1:0] CLAST = CW'(RQST_NUM - 1);
  localparam logic [DW-1:0] DLAST =
    DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    BEGIN,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  logic                  issue_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0]         cnt;
  logic [DW-1:0]         dcnt;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] step;

  // DRC0 withdraws the request; it also masks any DRC1 skip
  assign rqst.valid = issue_q & ~is_drc_i[0];
  assign rqst.addr  = addr;
  assign hs         = rqst.valid & rqst.ready;
  assign step       = is_drc_i[1] ? skip_operand_i
                                  : ADDR_WIDTH'(1);

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state       <= IDLE;
      issue_q     <= 1'b0;
      addr        <= BASE;
      cnt         <= '0;
      dcnt        <= '0;
      scu_begin_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      scu_begin_o <= 1'b0;
      done_o      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state       <= BEGIN;
            scu_begin_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        BEGIN: begin
          addr    <= BASE;
          cnt     <= '0;
          dcnt    <= '0;
          issue_q <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: begin
          if (hs) begin
            addr <= addr + step;
            cnt  <= cnt + CW'(1);
            if (cnt == CLAST) begin
              cnt     <= '0;
              dcnt    <= '0;
              issue_q <= 1'b0;
              if (DRAIN_CYC == 0) begin
                state  <= DONE;
                done_o <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (dcnt == DLAST) begin
            dcnt   <= '0;
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          issue_q <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/memshare_rqst_sched.md
# memShare_rqst_sched

Controller that sequences one SCU.memShare() period of message-passing buffer read requests. On a start pulse it rebases the read address to the buffer base and issues a fixed number of read requests through a valid/ready handshake. Each request address advances by 1, or by a DRC-supplied skip operand when a DRC1 result is present. After the last request it waits out the read pipeline, then signals completion. It sits between the layer-level scheduler and the message-passing buffer read port, alongside the memShare read-address operand logic.

## Interface
- ADDR_WIDTH, 6: message-passing buffer address width.
- ADDR_BASE, 0: rebase address loaded at period start.
- RQST_NUM, 16: read requests per memShare period (≥1).
- DRC_NUM, 2: DRC result vector width; bit 0 = DRC0 (stall), bit 1 = DRC1 (skip).
- DRAIN_CYC, 2: cycles waited after the last accepted request (matches read-operand pipeline depth).
- sys_clk  in  1  the single clock; all state updates on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- start_i  in  1  one-cycle pulse requesting a memShare period; ignored unless in IDLE.
- is_drc_i  in  DRC_NUM  DRC result for the current cycle.
- skip_operand_i  in  ADDR_WIDTH  address increment applied when DRC1 is set at a handshake.
- rqst_ready_i  in  1  the buffer read port accepts a request this cycle.
- rqst_valid_o  out  1  read request valid.
- rqst_addr_o  out  ADDR_WIDTH  read request address.
- scu_begin_o  out  1  one-cycle pulse marking the SCU.memShare() start.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at period end.

## Operation
- **States:** IDLE, BEGIN, ISSUE, DRAIN, DONE.
- **IDLE**
  - On start_i, go to BEGIN.
  - Otherwise hold; all outputs are low and rqst_addr_o is held.
- **BEGIN** (exactly 1 cycle)
  - scu_begin_o=1.
  - addr←ADDR_BASE, rqst count←0.
  - Go to ISSUE.
- **ISSUE**
  - rqst_valid_o = ~is_drc_i[0].
  - A handshake occurs when rqst_valid_o & rqst_ready_i.
  - On a handshake, the next address is addr + (is_drc_i[1] ? skip_operand_i : 1), computed modulo 2^ADDR_WIDTH so it wraps silently. The count increments.
  - The handshake that carries count==RQST_NUM-1 is the last one; go to DRAIN on that handshake.
  - If there is no handshake, addr and count hold. A request may not be withdrawn except by a DRC0 stall.
- **DRAIN**
  - A counter counts DRAIN_CYC cycles, then the FSM goes to DONE.
  - If DRAIN_CYC=0, go directly to DONE.
- **DONE** (1 cycle)
  - done_o=1, then go to IDLE.
- **Simultaneous events**
  - DRC0 and DRC1 in the same cycle: DRC0 wins; no request is issued and no increment occurs.
  - start_i in any state other than IDLE is dropped and not queued.
  - start_i in the DONE cycle is ignored.
  - start_i in the first IDLE cycle after DONE is accepted.
- **Reset**
  - rstn low in any state forces IDLE on the next edge.
  - Reset values: addr=ADDR_BASE, all counters 0, all outputs 0, rqst_addr_o=ADDR_BASE.
  - An in-flight period is abandoned without a done_o pulse.

## Timing
- start_i sampled at edge N gives scu_begin_o high in cycle N+1.
- The first rqst_valid_o is in cycle N+2, with rqst_addr_o=ADDR_BASE.
- rqst_addr_o is registered. It updates on the edge after a handshake, so back-to-back handshakes give one new address per cycle.
- Minimum period, with ready always high and no DRC: 1 (BEGIN) + RQST_NUM + DRAIN_CYC + 1 (DONE) cycles from the scu_begin_o cycle to the done_o cycle inclusive. With defaults that is 20 cycles.
- busy_o rises with scu_begin_o and falls the cycle after done_o.
- is_drc_i and skip_operand_i are sampled combinationally in the handshake cycle only.

## Test plan
- **Nominal period:** defaults, ready=1, no DRC, start pulse.
  - scu_begin_o pulses once.
  - Addresses 0..15 are issued in 16 consecutive cycles.
  - done_o pulses exactly 3 cycles after the last handshake.
  - Total is 20 cycles from scu_begin_o to done_o.
- **DRC1 skip:** is_drc_i=2'b10 with skip_operand_i=5 on the 3rd handshake.
  - Address sequence is 0,1,2,7,8,…
  - Exactly 16 requests are still issued.
- **DRC0 stall and priority:**
  - DRC0 high for 4 cycles mid-ISSUE: rqst_valid_o is low for those 4 cycles, address is held, and done_o is delayed by 4 cycles.
  - DRC0 and DRC1 together: stall only, no skip.
- **Backpressure and wrap:** ADDR_BASE=60, ADDR_WIDTH=6, ready toggling 1/0.
  - Addresses 60,61,62,63,0,1,… are issued only on ready cycles.
  - rqst_addr_o is held stable while ready=0.
- **Start filtering:**
  - start_i pulsed during ISSUE and during DONE: no second scu_begin_o.
  - start_i in the first IDLE cycle after DONE: a new period begins on the next cycle.
- **Reset mid-operation:** rstn=0 for 1 cycle during ISSUE.
  - Next cycle: IDLE, all outputs 0, rqst_addr_o=ADDR_BASE, no done_o.
  - A subsequent start runs a full clean period.
